// File: rtl/timed_cmd_dispatcher_pkg.sv
// Shared definitions for the timed command dispatcher: command-word layout,
// FSM encoding and the channel register-offset width.
package dispatcher_pkg;

  localparam int CH_OFS_W = 8;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_TIME = 2'd2,
    ISSUE     = 2'd3
  } state_e;

  // Command word is {timestamp, addr, data} with data in the low bits.
  function automatic int addr_lsb(int data_w);
    return data_w;
  endfunction

  function automatic int ts_lsb(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int cmd_w(int ts_w, int addr_w, int data_w);
    return ts_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/timed_cmd_dispatcher_ts_compare.sv
// Wrap-safe timestamp comparator: "due" once now has reached ts (or ts is the
// immediate value 0), "past" when now is strictly beyond a non-zero ts.
module ts_compare #(
  parameter int TS_W = 32
) (
  input  logic [TS_W-1:0] now,
  input  logic [TS_W-1:0] ts,
  output logic            due,
  output logic            past
);

  logic [TS_W-1:0] diff;
  logic            immediate;

  // The sign bit of the modular difference orders timestamps across wrap.
  assign diff      = now - ts;
  assign immediate = (ts == '0);
  assign due       = immediate || !diff[TS_W-1];
  assign past      = !immediate && !diff[TS_W-1] && (diff != '0);

endmodule

// File: rtl/timed_cmd_dispatcher.sv
// Pops timestamped commands from the command FIFO, holds each until its time
// is reached, then hands it to one channel controller over valid/ready.
module timed_cmd_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int               NUM_CH     = 16,
  parameter int               TS_W       = 32,
  parameter int               ADDR_W     = 16,
  parameter int               DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TS_W-1:0]               current_time,
  input  logic [TS_W+ADDR_W+DATA_W-1:0] fifo_dout,
  input  logic                          fifo_empty,
  input  logic                          fifo_valid,
  output logic                          fifo_rd_en,
  output logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH-1:0]             ch_ready,
  output logic [CH_OFS_W-1:0]           ch_addr,
  output logic [DATA_W-1:0]             ch_data,
  output logic                          reset_time,
  output logic                          late,
  output logic [15:0]                   drop_count,
  output logic                          busy,
  output state_e                        dbg_state
);

  localparam int TS_LSB   = ts_lsb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W    = ADDR_W - CH_OFS_W;

  // Channel handshake: ch_en[idx] is the valid; a transfer completes on the
  // first cycle where ch_en[idx] and ch_ready[idx] are both high. ch_addr and
  // ch_data are stable while ch_en is high.

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                first_q, first_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic [CH_OFS_W-1:0] ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]   ch_data_q, ch_data_d;
  logic                late_q, late_d;
  logic [15:0]         drop_q, drop_d;

  logic             due;
  logic             past;
  logic [IDX_W-1:0] idx;
  logic             unmapped;
  logic             is_reset_addr;
  logic             sel_ready;

  ts_compare #(.TS_W(TS_W)) u_ts_compare (
    .now  (current_time),
    .ts   (ts_q),
    .due  (due),
    .past (past)
  );

  assign idx           = addr_q[ADDR_W-1:CH_OFS_W];
  assign unmapped      = 32'(idx) >= 32'(NUM_CH);
  assign is_reset_addr = (addr_q == RESET_ADDR);
  assign sel_ready     = |(ch_ready & ch_en_q);

  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    addr_d    = addr_q;
    data_d    = data_q;
    first_d   = first_q;
    ch_en_d   = ch_en_q;
    ch_addr_d = ch_addr_q;
    ch_data_d = ch_data_q;
    late_d    = late_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        if (fifo_valid) begin
          ts_d    = fifo_dout[TS_LSB +: TS_W];
          addr_d  = fifo_dout[ADDR_LSB +: ADDR_W];
          data_d  = fifo_dout[DATA_LSB +: DATA_W];
          first_d = 1'b1;
          state_d = WAIT_TIME;
        end
      end
      WAIT_TIME: begin
        first_d = 1'b0;
        if (first_q && past) late_d = 1'b1;
        if (due) begin
          if (is_reset_addr) begin
            state_d = IDLE;
          end else if (unmapped) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = IDLE;
          end else begin
            ch_en_d   = NUM_CH'(1) << idx;
            ch_addr_d = addr_q[CH_OFS_W-1:0];
            ch_data_d = data_q;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          ch_en_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      first_q   <= 1'b0;
      ch_en_q   <= '0;
      ch_addr_q <= '0;
      ch_data_q <= '0;
      late_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      first_q   <= first_d;
      ch_en_q   <= ch_en_d;
      ch_addr_q <= ch_addr_d;
      ch_data_q <= ch_data_d;
      late_q    <= late_d;
      drop_q    <= drop_d;
    end
  end

  // Pop and clock-reset are decoded from state so neither costs a cycle;
  // both are held off while reset is asserted.
  assign fifo_rd_en = rst_n && (state_q == IDLE) && !fifo_empty;
  assign reset_time = rst_n && (state_q == WAIT_TIME) && due && is_reset_addr;
  assign ch_en      = ch_en_q;
  assign ch_addr    = ch_addr_q;
  assign ch_data    = ch_data_q;
  assign late       = late_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_timed_cmd_dispatcher.sv
// Directed bench for timed_cmd_dispatcher: a vector table of single commands
// plus hand-written backpressure and mid-operation reset sequences.
module tb_timed_cmd_dispatcher;
  import dispatcher_pkg::*;

  localparam int NUM_CH = 16;
  localparam int TS_W   = 32;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CMD_W  = TS_W + ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic [TS_W-1:0]   current_time;
  logic [CMD_W-1:0]  fifo_dout;
  logic              fifo_empty;
  logic              fifo_valid;
  logic              fifo_rd_en;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_ready;
  logic [7:0]        ch_addr;
  logic [DATA_W-1:0] ch_data;
  logic              reset_time;
  logic              late;
  logic [15:0]       drop_count;
  logic              busy;
  state_e            dbg_state;

  timed_cmd_dispatcher #(
    .NUM_CH(NUM_CH), .TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .current_time (current_time),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_valid   (fifo_valid),
    .fifo_rd_en   (fifo_rd_en),
    .ch_en        (ch_en),
    .ch_ready     (ch_ready),
    .ch_addr      (ch_addr),
    .ch_data      (ch_data),
    .reset_time   (reset_time),
    .late         (late),
    .drop_count   (drop_count),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [CMD_W-1:0] fifo_q[$];
  int tests = 0;
  int fails = 0;
  int rd_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: models a latency-1 FIFO and a free-running time counter.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    fifo_valid = 1'b0;
    if (rd && fifo_q.size() > 0) begin
      fifo_dout  = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end
    if (rd) rd_count++;
    fifo_empty   = (fifo_q.size() == 0);
    current_time = current_time + 1;
    #1;
  endtask

  task automatic push(input logic [31:0] ts, input logic [15:0] addr, input logic [31:0] data);
    fifo_q.push_back({ts, addr, data});
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    fifo_dout  = '0;
    ch_ready   = '0;
    step();
    step();
    rst_n    = 1'b1;
    rd_count = 0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] start;
    logic [31:0] ts;
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] exp_en;
    logic [31:0] exp_ct;
    logic        exp_late;
    logic [15:0] exp_drop;
    logic        exp_rt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic found;
    int   bad;

    current_time = '0;
    rst_n        = 1'b0;
    fifo_dout    = '0;
    fifo_empty   = 1'b1;
    fifo_valid   = 1'b0;
    ch_ready     = '0;

    // Event time = current_time when ch_en (or drop_count / reset_time) is first seen.
    vecs[0] = '{"immediate", 32'd1000,     32'd0,   16'h0305, 32'hDEADBEEF, 16'h0008, 32'd1003, 1'b0, 16'd0, 1'b0};
    vecs[1] = '{"timed",     32'd100,      32'd150, 16'h0210, 32'h12345678, 16'h0004, 32'd151,  1'b0, 16'd0, 1'b0};
    vecs[2] = '{"wrap",      32'hFFFFFFF0, 32'd5,   16'h0001, 32'h00000001, 16'h0001, 32'd6,    1'b0, 16'd0, 1'b0};
    vecs[3] = '{"late",      32'h0000000E, 32'd1,   16'h0F22, 32'hA5A5A5A5, 16'h8000, 32'h11,   1'b1, 16'd0, 1'b0};
    vecs[4] = '{"unmapped",  32'd10,       32'd0,   16'h1200, 32'h0BADF00D, 16'h0000, 32'd13,   1'b0, 16'd1, 1'b0};
    vecs[5] = '{"rst_addr",  32'd20,       32'd40,  16'hFFFF, 32'h00000000, 16'h0000, 32'd40,   1'b0, 16'd0, 1'b1};
    vecs[6] = '{"on_time",   32'd48,       32'd50,  16'h0A7F, 32'h00000000, 16'h0400, 32'd51,   1'b0, 16'd0, 1'b0};
    vecs[7] = '{"late_by_1", 32'd48,       32'd49,  16'h0B01, 32'hCAFE0001, 16'h0800, 32'd51,   1'b1, 16'd0, 1'b0};

    // reset state
    do_reset();
    check("rst_ch_en", ch_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_reset_time", reset_time, 0);
    check("rst_late", late, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ch_addr", ch_addr, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_state", dbg_state, IDLE);

    // vector table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      current_time = vecs[i].start;
      ch_ready     = '1;
      push(vecs[i].ts, vecs[i].addr, vecs[i].data);
      found = 1'b0;
      for (int c = 0; c < 80 && !found; c++) begin
        step();
        if (ch_en != 0 || reset_time || drop_count != 0) found = 1'b1;
      end
      check($sformatf("%s_found", vecs[i].name), found, 1);
      check($sformatf("%s_time", vecs[i].name), current_time, vecs[i].exp_ct);
      check($sformatf("%s_ch_en", vecs[i].name), ch_en, vecs[i].exp_en);
      check($sformatf("%s_ch_addr", vecs[i].name), ch_addr,
            (vecs[i].exp_en != 0) ? {56'h0, vecs[i].addr[7:0]} : 64'h0);
      check($sformatf("%s_ch_data", vecs[i].name), ch_data,
            (vecs[i].exp_en != 0) ? {32'h0, vecs[i].data} : 64'h0);
      check($sformatf("%s_late", vecs[i].name), late, vecs[i].exp_late);
      check($sformatf("%s_drop", vecs[i].name), drop_count, vecs[i].exp_drop);
      check($sformatf("%s_reset_time", vecs[i].name), reset_time, vecs[i].exp_rt);
      check($sformatf("%s_pops", vecs[i].name), rd_count, 1);
      step();
      check($sformatf("%s_en_after", vecs[i].name), ch_en, 0);
      check($sformatf("%s_rt_after", vecs[i].name), reset_time, 0);
      check($sformatf("%s_busy_after", vecs[i].name), busy, 0);
    end

    // backpressure: channel 7 stalls for 50 cycles, other channels ready
    do_reset();
    current_time = '0;
    ch_ready     = 16'hFF7F;
    push(32'd0, 16'h0712, 32'h77770000);
    push(32'd0, 16'h0134, 32'h11112222);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (ch_en != 0) found = 1'b1;
    end
    check("bp_found", found, 1);
    check("bp_ch_en", ch_en, 16'h0080);
    rd_count = 0;
    bad      = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (ch_en !== 16'h0080 || ch_addr !== 8'h12 || ch_data !== 32'h77770000 || busy !== 1'b1)
        bad++;
    end
    check("bp_stable_cycles", bad, 0);
    check("bp_no_pop", rd_count, 0);
    ch_ready = 16'h0080;
    step();
    check("bp_done_ch_en", ch_en, 0);
    check("bp_next_pop", fifo_rd_en, 1);
    ch_ready = '1;
    found    = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (ch_en != 0) found = 1'b1;
    end
    check("bp_second_found", found, 1);
    check("bp_second_ch_en", ch_en, 16'h0002);
    check("bp_second_data", ch_data, 32'h11112222);

    // reset during ISSUE after a drop and a late command
    do_reset();
    current_time = 32'h20;
    ch_ready     = '0;
    push(32'd0, 16'h1200, 32'h00000000);
    push(32'd1, 16'h0303, 32'h00000055);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step();
      if (ch_en != 0) found = 1'b1;
    end
    check("mid_found", found, 1);
    check("mid_ch_en", ch_en, 16'h0008);
    check("mid_late", late, 1);
    check("mid_drop", drop_count, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_ch_en", ch_en, 0);
    check("mid_rst_late", late, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ch_addr", ch_addr, 0);
    check("mid_rst_ch_data", ch_data, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_reset_time", reset_time, 0);
    rst_n    = 1'b1;
    ch_ready = '1;
    bad      = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ch_en != 0 || reset_time || fifo_rd_en || busy) bad++;
    end
    check("mid_no_completion", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timed_cmd_dispatcher.md
Name: timed_cmd_dispatcher

Overview:
Parametrised successor to the fixed command path between command_fifo, scheduler and the pin controllers. It pops timestamped command words from the command FIFO and waits until the global clock reaches each word's timestamp. It then delivers the word to one of NUM_CH channel controllers over a per-channel valid/ready handshake. Compared with the current path, it adds immediate mode, late-command detection, dropping of unmapped channels, and a timed global-clock reset.

Parameters:
NUM_CH, 16, number of channel controllers; 1..256.
TS_W, 32, timestamp and current_time width.
ADDR_W, 16, command address width; bits [ADDR_W-1:8] select the channel, bits [7:0] give the register offset.
DATA_W, 32, command payload width.
RESET_ADDR, all ones (ADDR_W bits), address that requests a global-clock reset instead of a channel write.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous reset, active-low.
current_time  in  TS_W  free-running global clock.
fifo_dout  in  TS_W+ADDR_W+DATA_W  command word {timestamp, addr, data}; MSB first.
fifo_empty  in  1  FIFO empty.
fifo_valid  in  1  fifo_dout valid; arrives one or more cycles after fifo_rd_en.
fifo_rd_en  out  1  one-cycle pop request.
ch_en  out  NUM_CH  one-hot command valid.
ch_ready  in  NUM_CH  per-channel accept.
ch_addr  out  8  register offset.
ch_data  out  DATA_W  payload.
reset_time  out  1  one-cycle pulse that clears the global clock.
late  out  1  sticky: a command was issued after its timestamp.
drop_count  out  16  count of dropped commands (unmapped channel); saturates at 0xFFFF.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, holding registers cleared.
- Reset mid-operation aborts any in-flight command; the popped word is lost. No ch_en or reset_time may follow.
- State IDLE: if !fifo_empty, assert fifo_rd_en for exactly one cycle and go to FETCH.
- State FETCH: wait for fifo_valid, then latch ts, addr and data, and go to WAIT_TIME.
  - fifo_rd_en stays low while in FETCH.
- State WAIT_TIME: the command is due when ts==0 (immediate mode) or when $signed(current_time - ts) >= 0, evaluated as a wrap-safe TS_W-bit difference.
  - If the difference is greater than 0 at the first WAIT_TIME cycle and ts != 0, set late.
  - Once due:
    - addr==RESET_ADDR: pulse reset_time for 1 cycle, return to IDLE.
    - channel index >= NUM_CH: increment drop_count (saturating), return to IDLE.
    - otherwise: go to ISSUE.
- Issue latency: when ts == current_time on the first WAIT_TIME cycle, ch_en rises on the next cycle. This is 1 cycle, and no further cycles may be lost.
- State ISSUE: drive ch_en[idx]=1 with ch_addr and ch_data held stable.
  - On the first cycle where ch_ready[idx]=1, the transfer completes: ch_en drops the next cycle and the state returns to IDLE.
  - ch_ready on non-selected channels is ignored.
  - A channel that never asserts ready stalls the dispatcher indefinitely. This is intended; there is no timeout.
- Ordering: strictly FIFO order. A future-timestamped head blocks later words, including immediate ones.
- Throughput: at most one command per 4 cycles (IDLE, FETCH, WAIT_TIME, ISSUE) with a ready channel and FIFO latency 1.
- late is sticky; only reset clears it.
- ch_addr and ch_data hold their last value outside ISSUE.
- Simultaneous events:
  - reset_time issued while a later word's ts is compared: the comparison uses current_time as presented, so the clock reset is seen from the next cycle.
  - fifo_empty rising while in FETCH does not cancel the pending fifo_valid.

Decomposition:
- Shared package dispatcher_pkg: field offsets (TS_LSB, ADDR_LSB, DATA_LSB), the command-word width function, the state encoding (IDLE, FETCH, WAIT_TIME, ISSUE), and CH_OFS_W=8.
- One natural sub-module: ts_compare, a wrap-safe due/late comparator parametrised by TS_W and reusable by sample_collector timing.

Test Plan:
- Immediate: word {ts=0, addr=0x0305, data=0xDEADBEEF}, NUM_CH=16, ch_ready[3]=1 -> fifo_rd_en pulse, ch_en=0x0008 for 1 cycle, ch_addr=0x05, ch_data=0xDEADBEEF, late=0.
- Timed: current_time=100, ts=150 to channel 2 -> ch_en[2] first rises when current_time=151 (1-cycle latency), held until ch_ready[2]; late=0.
- Late and wrap: current_time=0xFFFFFFF0, ts=0x00000005 -> waits 21 cycles across the wrap, late=0. A second word with ts=0x00000001 issued at current_time=0x10 -> issues immediately, late=1.
- Backpressure: ch_ready[7] held low for 50 cycles -> ch_en[7] stable high for 50 cycles, no further fifo_rd_en, busy=1. Ready high -> completes, next word popped.
- Unmapped and reset: addr=0x1200 with NUM_CH=16 -> no ch_en, drop_count 0->1. addr=0xFFFF with ts=40 -> single reset_time pulse at current_time=40.
- Mid-operation reset: rst_n low for 1 cycle during ISSUE -> all outputs 0 the next cycle, no completion, late and drop_count cleared.
